fetch_mem_unit: RTL
===================

Name: fetch_mem_unit

Overview:
- Multicycle datapath front end that sits directly upstream of the control FSM.
- Holds PC, PCBack, IR and MDR, and drives the shared instruction/data memory through a req/ready handshake.
- IR output is the instruction word decoded by the control FSM; PC write-enable, PC-source, IorD, MemRead/MemWrite and IRWrite strobes come from that FSM.
- Stretches any memory access with wait states and raises oStall; the control FSM holds its current state while oStall=1.

Parameters:
RESET_PC, 32'h0040_0000, PC value after reset
TIMEOUT, 16, max BUSY cycles without iMemReady before error
CNT_W, 5, width of wait-cycle counter (must hold TIMEOUT)

Ports:
iClk  input  1  clock, all state updates on rising edge
iRst  input  1  synchronous reset, active-high
iWritePC  input  1  unconditional PC write
iWritePCCond  input  1  PC write if iZero
iZero  input  1  ALU zero flag (branch condition)
iWritePCB  input  1  copy PC into PCBack
iWriteIR  input  1  load IR from the completing memory read
iLoadD  input  1  memory address select: 0=PC, 1=iALUOut
iMemRead  input  1  request memory read
iMemWrite  input  1  request memory write
iOrigPC  input  2  next-PC source: 00 iALUResult, 01 iALUOut, 10 {iALUResult[31:1],1'b0}, 11 hold
iALUResult  input  32  combinational ALU result
iALUOut  input  32  registered ALU result
iStoreData  input  32  rs2 data for stores
iMemRData  input  32  memory read data, valid with iMemReady
iMemReady  input  1  memory completes the access this cycle
oMemReq  output  1  access outstanding
oMemWe  output  1  1=write, 0=read (valid with oMemReq)
oMemAddr  output  32  latched access address
oMemWData  output  32  latched write data
oPC  output  32  current PC
oPCBack  output  32  PC of the instruction in IR
oInst  output  32  instruction register
oMDR  output  32  memory data register
oStall  output  1  control FSM must hold state
oMemErr  output  1  sticky access error

Behaviour:
- Reset values: PC=RESET_PC; PCBack, IR, MDR, oMemAddr, oMemWData = 0; oMemReq=0, oMemWe=0, oMemErr=0; FSM=IDLE; wait counter=0.
- iRst during BUSY aborts the access. oMemReq is 0 from the next cycle and no register is written by that access.
- Access FSM states: IDLE, BUSY, ERROR.
- IDLE, no request: oStall=0.
- IDLE, valid request (exactly one of iMemRead/iMemWrite, address[1:0]=00):
  - latch address (iLoadD ? iALUOut : PC), iStoreData, we=iMemWrite, and the iWriteIR intent;
  - go to BUSY; oStall=1 this cycle.
- IDLE, both iMemRead and iMemWrite high, or misaligned address: go to ERROR, set oMemErr; no oMemReq is issued.
- BUSY: oMemReq=1 and oStall=!iMemReady; counter increments each cycle.
  - iMemReady=1 on a read: MDR<=iMemRData; IR<=iMemRData if the latched IRWrite intent was 1; go to IDLE; clear counter.
  - iMemReady=1 on a write: no register capture; go to IDLE.
  - Counter reaches TIMEOUT with iMemReady=0: go to ERROR, set oMemErr, drop oMemReq.
- ERROR: oStall=1 and oMemErr=1 until iRst.
- Minimum access latency is 2 cycles: request cycle, then BUSY with iMemReady=1. Each cycle iMemReady stays low adds one cycle.
- PC update:
  - condition: (iWritePC | (iWritePCCond & iZero)) & !oStall;
  - the source is selected by iOrigPC;
  - iOrigPC=11 holds PC.
  - In a fetch the PC write coincides with the completing edge. oMemAddr is latched, so the in-flight address is unaffected.
- PCBack <= PC when iWritePCB & !oStall.
- All strobes are ignored while oStall=1, except the request already latched.
- Arithmetic: no internal adders; widths are fixed at 32 bits; PC is not wrapped or checked beyond bit 0 clearing for source 10.

Test Plan:
- Reset, then fetch (iMemRead=1, iWriteIR=1, iWritePC=1, iOrigPC=00, iALUResult=0x00400004, iMemReady=1 on the first BUSY cycle):
  - oMemAddr=0x00400000;
  - oStall=1 for exactly 1 cycle;
  - IR=MDR=iMemRData (e.g. 0x00A00093), then PC=0x00400004.
- Same fetch with iMemReady delayed 3 cycles: oStall high 4 cycles; PC and IR unchanged until the completing edge.
- Branch, no memory access, iWritePCCond=1, iOrigPC=01, iALUOut=0x00400020:
  - iZero=1 → PC=0x00400020;
  - iZero=0 → PC unchanged.
- Load, iLoadD=1, iALUOut=0x10010004: oMemAddr=0x10010004, oMemWe=0, MDR captured, IR unchanged.
- Store, iALUOut=0x10010002 (misaligned): oMemErr=1, oMemReq never asserts, oStall stays 1.
- iMemReady held low for TIMEOUT=16 cycles → oMemErr=1. Separately, iRst mid-BUSY → oMemReq=0 next cycle, PC=0x00400000.

Source files
------------

// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit
// Multicycle datapath front end: holds PC, PCBack, IR and MDR and drives the
// shared instruction/data memory through a req/ready handshake. Any memory
// access raises oStall until the memory completes it, so the control FSM
// holds its state while oStall=1.
//
// Ports:
//   iClk, iRst            clock, synchronous active-high reset
//   iWritePC/iWritePCCond PC write strobes (the conditional one uses iZero)
//   iWritePCB             copy PC into PCBack
//   iWriteIR              load IR from the completing read
//   iLoadD                address select: 0=PC, 1=iALUOut
//   iMemRead/iMemWrite    access request
//   iOrigPC               next-PC source select
//   iALUResult/iALUOut    combinational / registered ALU results
//   iStoreData            store data
//   iMemRData/iMemReady   memory read data and completion
//   oMemReq/oMemWe/oMemAddr/oMemWData  memory request side
//   oPC/oPCBack/oInst/oMDR architectural registers
//   oStall/oMemErr        hold request to the control FSM, sticky error
module fetch_mem_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iWritePC,
  input  logic        iWritePCCond,
  input  logic        iZero,
  input  logic        iWritePCB,
  input  logic        iWriteIR,
  input  logic        iLoadD,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [1:0]  iOrigPC,
  input  logic [31:0] iALUResult,
  input  logic [31:0] iALUOut,
  input  logic [31:0] iStoreData,
  input  logic [31:0] iMemRData,
  input  logic        iMemReady,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  output logic [31:0] oPC,
  output logic [31:0] oPCBack,
  output logic [31:0] oInst,
  output logic [31:0] oMDR,
  output logic        oStall,
  output logic        oMemErr
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    ERROR = 2'b10
  } state_t;

  // Last BUSY cycle index before the access is declared dead.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r, nextState_s;
  logic [CNT_W-1:0] waitCnt_r;
  logic [31:0]      pc_r, pcBack_r, inst_r, mdr_r, memAddr_r, memWData_r;
  logic             memReq_r, memWe_r, memErr_r, irIntent_r;
  logic [31:0]      reqAddr_s, nextPc_s;
  logic             reqAny_s, reqBad_s, reqOk_s;
  logic             stall_s, done_s, timeout_s, pcWrite_s;

  // Request decode: address select and legality of the requested access.
  always_comb begin
    reqAddr_s = iLoadD ? iALUOut : pc_r;
    reqAny_s  = iMemRead | iMemWrite;
    reqBad_s  = (iMemRead & iMemWrite) | (reqAny_s & (reqAddr_s[1:0] != 2'b00));
    reqOk_s   = reqAny_s & ~reqBad_s;
  end

  // Access FSM next state and stall generation.
  always_comb begin
    nextState_s = state_r;
    stall_s     = 1'b0;
    done_s      = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (reqBad_s) begin
          nextState_s = ERROR;
          stall_s     = 1'b1;
        end else if (reqOk_s) begin
          nextState_s = BUSY;
          stall_s     = 1'b1;
        end else begin
          stall_s     = 1'b0;
        end
      end
      BUSY: begin
        if (iMemReady) begin
          // Completing cycle: stall drops so this edge also commits PC/PCBack.
          nextState_s = IDLE;
          done_s      = 1'b1;
        end else if (waitCnt_r == CNT_LAST) begin
          nextState_s = ERROR;
          stall_s     = 1'b1;
          timeout_s   = 1'b1;
        end else begin
          stall_s     = 1'b1;
        end
      end
      ERROR: begin
        stall_s = 1'b1;
      end
      default: begin
        nextState_s = IDLE;
        stall_s     = 1'b1;
      end
    endcase
  end

  // Next-PC source mux; source 11 holds the current PC.
  always_comb begin
    case (iOrigPC)
      2'b00:   nextPc_s = iALUResult;
      2'b01:   nextPc_s = iALUOut;
      2'b10:   nextPc_s = {iALUResult[31:1], 1'b0};
      default: nextPc_s = pc_r;
    endcase
    pcWrite_s = (iWritePC | (iWritePCCond & iZero)) & ~stall_s;
  end

  // Access FSM state register.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Wait-cycle counter: counts BUSY cycles, cleared on completion.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      waitCnt_r <= '0;
    end else if (state_r == BUSY) begin
      waitCnt_r <= done_s ? '0 : (waitCnt_r + CNT_ONE);
    end else if (state_r == IDLE) begin
      waitCnt_r <= '0;
    end
  end

  // Latched request: address, data, direction and IR intent are frozen
  // at the request so later PC or strobe changes cannot disturb the access.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      memReq_r   <= 1'b0;
      memWe_r    <= 1'b0;
      memAddr_r  <= 32'h0000_0000;
      memWData_r <= 32'h0000_0000;
      irIntent_r <= 1'b0;
    end else if ((state_r == IDLE) && reqOk_s) begin
      memReq_r   <= 1'b1;
      memWe_r    <= iMemWrite;
      memAddr_r  <= reqAddr_s;
      memWData_r <= iStoreData;
      irIntent_r <= iWriteIR;
    end else if (done_s | timeout_s) begin
      memReq_r   <= 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      memErr_r <= 1'b0;
    end else if (((state_r == IDLE) && reqBad_s) | timeout_s) begin
      memErr_r <= 1'b1;
    end
  end

  // Read-data capture into MDR and, when requested, IR.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      mdr_r  <= 32'h0000_0000;
      inst_r <= 32'h0000_0000;
    end else if (done_s & ~memWe_r) begin
      mdr_r <= iMemRData;
      if (irIntent_r) begin
        inst_r <= iMemRData;
      end
    end
  end

  // PC and PCBack updates, both frozen while stalled.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pc_r     <= RESET_PC;
      pcBack_r <= 32'h0000_0000;
    end else begin
      if (pcWrite_s) begin
        pc_r <= nextPc_s;
      end
      if (iWritePCB & ~stall_s) begin
        pcBack_r <= pc_r;
      end
    end
  end

  assign oMemReq   = memReq_r;
  assign oMemWe    = memWe_r;
  assign oMemAddr  = memAddr_r;
  assign oMemWData = memWData_r;
  assign oPC       = pc_r;
  assign oPCBack   = pcBack_r;
  assign oInst     = inst_r;
  assign oMDR      = mdr_r;
  assign oStall    = stall_s;
  assign oMemErr   = memErr_r;

endmodule
